// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with write-first read bypass and a per-register busy scoreboard
module regfile_mp #(
    parameter int width      = 32,
    parameter int addrWidth  = 5,
    parameter int readPorts  = 2,
    parameter int writePorts = 2,
    parameter int zeroReg    = 1
) (
    input  logic                            clock,
    input  logic                            clear,
    input  logic [readPorts-1:0]            readEnable,
    input  logic [readPorts*addrWidth-1:0]  addrR,
    output logic [readPorts*width-1:0]      dataR,
    output logic [readPorts-1:0]            busyR,
    input  logic [writePorts-1:0]           writeEnable,
    input  logic [writePorts*addrWidth-1:0] addrW,
    input  logic [writePorts*width-1:0]     dataW,
    input  logic                            issueEnable,
    input  logic [addrWidth-1:0]            addrIssue
);
    localparam int DEPTH = 1 << addrWidth;
    localparam bit ZR = (zeroReg != 0);

    logic [width-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_busy;
    logic [width-1:0] w_mem [DEPTH];
    logic [DEPTH-1:0] w_busy;

    // Post-edge view of storage: writes in port order (highest port wins), then issue overrides busy
    always_comb begin
        w_mem  = r_mem;
        w_busy = r_busy;
        for (int w = 0; w < writePorts; w++)
            if (writeEnable[w] && !(ZR && addrW[w*addrWidth +: addrWidth] == '0)) begin
                w_mem[addrW[w*addrWidth +: addrWidth]]  = dataW[w*width +: width];
                w_busy[addrW[w*addrWidth +: addrWidth]] = 1'b0;
            end
        if (issueEnable && !(ZR && addrIssue == '0))
            w_busy[addrIssue] = 1'b1;
    end

    // Commit storage and scoreboard; clear wipes everything asynchronously
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_mem  <= '{default: '0};
            r_busy <= '0;
        end else begin
            r_mem  <= w_mem;
            r_busy <= w_busy;
        end
    end

    // Registered reads from the post-edge view, giving write-first bypass; disabled ports hold
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            dataR <= '0;
            busyR <= '0;
        end else begin
            for (int p = 0; p < readPorts; p++)
                if (readEnable[p]) begin
                    dataR[p*width +: width] <= w_mem[addrR[p*addrWidth +: addrWidth]];
                    busyR[p]                <= w_busy[addrR[p*addrWidth +: addrWidth]];
                end
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized bench against an array model, for zeroReg=1 (k=0) and zeroReg=0 (k=1)
module tb_regfile_mp;
    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  readEnable, writeEnable;
    logic [9:0]  addrR, addrW;
    logic [63:0] dataW;
    logic        issueEnable;
    logic [4:0]  addrIssue;
    logic [63:0] dataR0, dataR1;
    logic [1:0]  busyR0, busyR1;
    int          pass = 0, total = 0;
    bit          started = 0;

    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];
    logic [31:0] e_d    [2][2];
    logic        e_b    [2][2];
    logic [31:0] nm [32];
    logic        nb [32];
    int          a;

    always #5 clock = ~clock;

    regfile_mp #(.zeroReg(1)) dut (
        .clock(clock), .clear(clear), .readEnable(readEnable), .addrR(addrR),
        .dataR(dataR0), .busyR(busyR0), .writeEnable(writeEnable), .addrW(addrW),
        .dataW(dataW), .issueEnable(issueEnable), .addrIssue(addrIssue)
    );
    regfile_mp #(.zeroReg(0)) dut_nz (
        .clock(clock), .clear(clear), .readEnable(readEnable), .addrR(addrR),
        .dataR(dataR1), .busyR(busyR1), .writeEnable(writeEnable), .addrW(addrW),
        .dataW(dataW), .issueEnable(issueEnable), .addrIssue(addrIssue)
    );

    // Reference model: registers and busy bits as plain arrays, updated per the edge rules
    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 32; i++) begin
                    m_mem[k][i]  = '0;
                    m_busy[k][i] = 1'b0;
                end
                for (int p = 0; p < 2; p++) begin
                    e_d[k][p] = '0;
                    e_b[k][p] = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 32; i++) begin
                    nm[i] = m_mem[k][i];
                    nb[i] = m_busy[k][i];
                end
                for (int w = 0; w < 2; w++) begin
                    a = int'(addrW[w*5 +: 5]);
                    if (writeEnable[w] && !(k == 0 && a == 0)) begin
                        nm[a] = dataW[w*32 +: 32];
                        nb[a] = 1'b0;
                    end
                end
                if (issueEnable && !(k == 0 && addrIssue == 5'd0)) nb[addrIssue] = 1'b1;
                for (int p = 0; p < 2; p++)
                    if (readEnable[p]) begin
                        a = int'(addrR[p*5 +: 5]);
                        e_d[k][p] = nm[a];
                        e_b[k][p] = nb[a];
                    end
                for (int i = 0; i < 32; i++) begin
                    m_mem[k][i]  = nm[i];
                    m_busy[k][i] = nb[i];
                end
            end
        end
    end

    function automatic logic [31:0] got_d(int k, int p);
        return k != 0 ? dataR1[p*32 +: 32] : dataR0[p*32 +: 32];
    endfunction

    function automatic logic got_b(int k, int p);
        return k != 0 ? busyR1[p] : busyR0[p];
    endfunction

    task automatic chk(input string nm_s, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s got=%h exp=%h at %0t", nm_s, got, exp, $time);
    endtask

    task automatic lit(input string nm_s, input int k, input int p, input logic [31:0] d, input logic b);
        chk({nm_s, "_data"}, got_d(k, p), d);
        chk({nm_s, "_busy"}, {31'b0, got_b(k, p)}, {31'b0, b});
        chk({nm_s, "_model"}, e_d[k][p], d);
    endtask

    // Every negedge: both instances, both ports, against the model
    always @(negedge clock)
        if (started)
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) begin
                    chk($sformatf("cmp_data k%0d p%0d", k, p), got_d(k, p), e_d[k][p]);
                    chk($sformatf("cmp_busy k%0d p%0d", k, p), {31'b0, got_b(k, p)}, {31'b0, e_b[k][p]});
                end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        readEnable  = '0;
        writeEnable = '0;
        issueEnable = 1'b0;
    endtask

    task automatic wr(input int w, input logic [4:0] ad, input logic [31:0] d);
        writeEnable[w]  = 1'b1;
        addrW[w*5 +: 5] = ad;
        dataW[w*32 +: 32] = d;
    endtask

    task automatic rd(input int p, input logic [4:0] ad);
        readEnable[p]   = 1'b1;
        addrR[p*5 +: 5] = ad;
    endtask

    task automatic iss(input logic [4:0] ad);
        issueEnable = 1'b1;
        addrIssue   = ad;
    endtask

    function automatic logic [4:0] ra();
        return $urandom_range(0, 3) != 0 ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        idle();
        addrR = '0; addrW = '0; dataW = '0; addrIssue = '0;
        repeat (2) step();
        clear = 1'b1;
        started = 1;
        lit("rst", 0, 0, 32'h0, 1'b0);
        lit("rst", 1, 1, 32'h0, 1'b0);
        wr(0, 5'd5, 32'hDEADBEEF); rd(0, 5'd5); step(); idle();
        lit("bypass_x5", 0, 0, 32'hDEADBEEF, 1'b0);
        #2 clear = 1'b0;
        #1 lit("clr_async", 0, 0, 32'h0, 1'b0);
        lit("clr_async_nz", 1, 0, 32'h0, 1'b0);
        @(posedge clock);
        #2 clear = 1'b1;
        rd(0, 5'd5); step(); idle();
        lit("after_clr", 0, 0, 32'h0, 1'b0);
        wr(0, 5'd7, 32'h12345678); step(); idle();
        rd(0, 5'd7); rd(1, 5'd7); step(); idle();
        lit("rd_x7_p0", 0, 0, 32'h12345678, 1'b0);
        lit("rd_x7_p1", 0, 1, 32'h12345678, 1'b0);
        wr(0, 5'd3, 32'hAAAA0000); wr(1, 5'd3, 32'h5555FFFF); rd(0, 5'd3); step(); idle();
        lit("prio_bypass", 0, 0, 32'h5555FFFF, 1'b0);
        rd(1, 5'd3); step(); idle();
        lit("prio_later", 0, 1, 32'h5555FFFF, 1'b0);
        wr(0, 5'd0, 32'hFFFFFFFF); iss(5'd0); step(); idle();
        rd(0, 5'd0); step(); idle();
        lit("x0_zero", 0, 0, 32'h0, 1'b0);
        lit("x0_plain", 1, 0, 32'hFFFFFFFF, 1'b1);
        iss(5'd9); step(); idle();
        rd(0, 5'd9); step(); idle();
        lit("sb_issue", 0, 0, 32'h0, 1'b1);
        wr(1, 5'd9, 32'h42); rd(0, 5'd9); step(); idle();
        lit("sb_write", 0, 0, 32'h42, 1'b0);
        iss(5'd9); wr(0, 5'd9, 32'h77); rd(0, 5'd9); step(); idle();
        lit("sb_both", 0, 0, 32'h77, 1'b1);
        wr(0, 5'd4, 32'h11); rd(0, 5'd4); step(); idle();
        lit("hold_first", 0, 0, 32'h11, 1'b0);
        wr(0, 5'd4, 32'h22); step(); idle();
        lit("hold_wr", 0, 0, 32'h11, 1'b0);
        step();
        lit("hold_idle", 0, 0, 32'h11, 1'b0);
        rd(0, 5'd4); step(); idle();
        lit("hold_reread", 0, 0, 32'h22, 1'b0);
        repeat (3000) begin
            idle();
            clear = 1'b1;
            for (int w = 0; w < 2; w++) if ($urandom_range(0, 1) != 0) wr(w, ra(), $urandom());
            for (int p = 0; p < 2; p++) if ($urandom_range(0, 2) != 0) rd(p, ra());
            if ($urandom_range(0, 3) == 0) iss(ra());
            if ($urandom_range(0, 299) == 0) #2 clear = 1'b0;
            step();
        end
        idle();
        clear = 1'b1;
        step();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
